// File: rtl/rll_key_loader.sv
// Key loader and single-shot evaluation sequencer for an RLL-locked combinational core.
// Loads a chunked key with an XOR checksum, then drives registered PIs and captures POs after a settle interval.
module rll_key_loader #(
  parameter int KEY_WIDTH     = 32,
  parameter int CHUNK_WIDTH   = 8,
  parameter int NUM_PI        = 18,
  parameter int NUM_PO        = 18,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CHUNK_WIDTH-1:0] cfg_data,
  input  logic                   cfg_last,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic                   key_valid,
  output logic                   load_err,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [NUM_PI-1:0]      req_data,
  output logic [NUM_PI-1:0]      core_pi,
  input  logic [NUM_PO-1:0]      core_po,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NUM_PO-1:0]      rsp_data
);

  localparam int NUM_BEATS = KEY_WIDTH / CHUNK_WIDTH;
  localparam int BW        = $clog2(NUM_BEATS + 2);
  localparam int SW        = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ARMED = 3'd3;
  localparam logic [2:0] S_EVAL  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]             state;
  logic [BW-1:0]          beat_cnt;
  logic [CHUNK_WIDTH-1:0] acc;
  logic [CHUNK_WIDTH-1:0] chk;
  logic [SW-1:0]          settle_cnt;

  logic cfg_fire;
  logic req_fire;
  logic start_ok;

  // After the checksum beat (beat_cnt = N+1) LOAD spends one drain cycle with
  // cfg_ready low before entering CHECK, so the verdict lands two edges later.
  assign cfg_ready = (state == S_LOAD) && (beat_cnt <= BW'(NUM_BEATS));
  assign req_ready = (state == S_ARMED);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign req_fire  = req_valid && req_ready;
  assign start_ok  = cfg_start && ((state == S_IDLE) || (state == S_LOAD) ||
                                   (state == S_ARMED) || (state == S_ERROR));

  // NOTE: every register below uses non-blocking (<=) assignments so all state
  // updates see pre-edge values, matching flip-flop behaviour in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      acc        <= '0;
      chk        <= '0;
      settle_cnt <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      load_err   <= 1'b0;
      core_pi    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else if (start_ok) begin
      state     <= S_LOAD;
      beat_cnt  <= '0;
      acc       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat_cnt > BW'(NUM_BEATS)) begin
            state <= S_CHECK;
          end else if (cfg_fire) begin
            if (beat_cnt == BW'(NUM_BEATS)) begin
              if (cfg_last) begin
                chk      <= cfg_data;
                beat_cnt <= beat_cnt + BW'(1);
              end else begin
                state    <= S_ERROR;
                key_out  <= '0;
                load_err <= 1'b1;
              end
            end else if (cfg_last) begin
              state    <= S_ERROR;
              key_out  <= '0;
              load_err <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_BEATS; k++) begin
                if (beat_cnt == BW'(k)) key_out[k*CHUNK_WIDTH +: CHUNK_WIDTH] <= cfg_data;
              end
              acc      <= acc ^ cfg_data;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        S_CHECK: begin
          if (acc == chk) begin
            state     <= S_ARMED;
            key_valid <= 1'b1;
          end else begin
            state     <= S_ERROR;
            key_out   <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (req_fire) begin
            core_pi    <= req_data;
            settle_cnt <= SW'(SETTLE_CYCLES);
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (settle_cnt == SW'(1)) begin
            rsp_data  <= core_po;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_ARMED;
          end
        end
        default: ; // IDLE and ERROR wait for cfg_start
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader: randomized key loads and evaluations against a
// behavioural model; a monitor pops expected responses on every response handshake.
`timescale 1ns/1ps
module tb_rll_key_loader;
  localparam int KW = 32, CW = 8, NPI = 18, NPO = 18, SC = 2, NB = KW / CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic cfg_ready, key_valid, load_err, req_ready, rsp_valid;
  logic [KW-1:0] key_out;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [NPI-1:0] req_data = '0;
  logic [NPI-1:0] core_pi;
  logic [NPO-1:0] core_po, rsp_data;

  always #5 clk = ~clk;

  rll_key_loader #(
    .KEY_WIDTH(KW), .CHUNK_WIDTH(CW), .NUM_PI(NPI), .NUM_PO(NPO), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last),
    .key_out(key_out), .key_valid(key_valid), .load_err(load_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .core_pi(core_pi), .core_po(core_po),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  // Stand-in locked core: output depends on both the inputs and the applied key.
  function automatic logic [NPO-1:0] core_fn(input logic [NPI-1:0] pi, input logic [KW-1:0] k);
    return (pi ^ k[NPI-1:0]) + k[KW-1:KW-NPO];
  endfunction
  assign core_po = core_fn(core_pi, key_out);

  int n_cmp = 0, n_fail = 0;
  logic [KW-1:0]  m_key = '0;
  bit             m_armed = 0;
  logic [NPO-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string msg);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", msg, $time);
  endtask

  // Response monitor: stability while waiting, scoreboard compare on handshake.
  bit held = 0;
  logic [NPO-1:0] held_data;
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (rsp_valid) begin
      if (held) check("rsp_stable", rsp_data, held_data);
      else begin held = 1; held_data = rsp_data; end
      if (rsp_ready) begin
        if (exp_q.size() == 0) fail_now("rsp_unexpected: response with empty scoreboard");
        else check("rsp_data", rsp_data, exp_q.pop_front());
        held = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals();
    check("rst_key_out", key_out, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_load_err", load_err, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_pi", core_pi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
  endtask

  task automatic cfg_beat(input logic [CW-1:0] d, input bit last, output bit ok);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    while (!cfg_ready && n < 20) begin @(negedge clk); n++; end
    ok = cfg_ready;
    if (!ok) fail_now("cfg_timeout: cfg_ready stayed 0 for 20 cycles");
    else @(posedge clk);
    #1;
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk); cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    m_armed = 0; m_key = '0;
    check("start_key_out", key_out, 0);
    check("start_key_valid", key_valid, 0);
    check("start_load_err", load_err, 0);
  endtask

  // last_at: beat index carrying cfg_last (NB is correct framing, NB+1 means never).
  task automatic load_key(input logic [KW-1:0] key, input logic [CW-1:0] chk,
                          input int last_at, input int stall_beat);
    bit ok, last, good;
    logic [CW-1:0] d, x;
    logic [63:0] m64;
    start_load();
    for (int k = 0; k <= NB; k++) begin
      last = (k == last_at);
      d = (k < NB) ? key[k*CW +: CW] : chk;
      cfg_beat(d, last, ok);
      if (!ok) return;
      if ((k < NB && last) || (k == NB && !last)) begin
        check("frame_load_err", load_err, 1);
        check("frame_key_out", key_out, 0);
        check("frame_key_valid", key_valid, 0);
        check("frame_cfg_ready", cfg_ready, 0);
        return;
      end
      if (k < NB) begin
        m64 = (64'd1 << (CW * (k + 1))) - 64'd1;
        check("key_partial", key_out, key & m64[KW-1:0]);
        if (k == stall_beat) begin
          repeat (5) @(negedge clk);
          check("key_stall_hold", key_out, key & m64[KW-1:0]);
        end
      end
    end
    x = '0;
    for (int i = 0; i < NB; i++) x ^= key[i*CW +: CW];
    good = (x == chk);
    tick();
    check("check_pending_valid", key_valid, 0);
    check("check_cfg_ready", cfg_ready, 0);
    tick();
    check("verdict_key_valid", key_valid, good);
    check("verdict_load_err", load_err, !good);
    check("verdict_key_out", key_out, good ? key : '0);
    check("verdict_req_ready", req_ready, good);
    m_armed = good;
    m_key = good ? key : '0;
  endtask

  task automatic do_eval(input logic [NPI-1:0] pi, input int hold, input bit poke_start);
    int n = 0, lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_data = pi; rsp_ready = (hold == 0);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      fail_now("req_timeout: req_ready stayed 0 for 20 cycles");
      req_valid = 1'b0; rsp_ready = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(core_fn(pi, m_key));
    #1; req_valid = 1'b0;
    check("core_pi", core_pi, pi);
    check("req_ready_busy", req_ready, 0);
    if (poke_start) cfg_start = 1'b1;
    while (!rsp_valid && lat < 50) begin
      tick(); cfg_start = 1'b0; lat++;
    end
    check("rsp_latency", lat, SC);
    check("eval_key_out", key_out, m_key);
    check("eval_key_valid", key_valid, 1);
    repeat (hold) begin
      tick();
      check("resp_hold_valid", rsp_valid, 1);
      check("resp_hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", rsp_valid, 0);
    check("rearmed_req_ready", req_ready, 1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    m_armed = 0; m_key = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    check_reset_vals();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] key;
    logic [CW-1:0] x;
    bit ok;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    tick();
    check_reset_vals();

    load_key(32'hA5C30F12, 8'h7B, NB, -1);
    do_eval(18'h2AAAA, 4, 1'b0);
    do_eval(NPI'($urandom), 0, 1'b1);

    load_key(32'hA5C30F12, 8'h7A, NB, -1);
    repeat (3) begin tick(); check("error_req_ready", req_ready, 0); end
    load_key(32'hA5C30F12, 8'h7B, 2, -1);
    load_key(32'hA5C30F12, 8'h7B, NB + 1, -1);
    load_key(32'hA5C30F12, 8'h7B, NB, 1);
    do_eval(NPI'($urandom), 1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      key = $urandom;
      x = '0;
      for (int i = 0; i < NB; i++) x ^= key[i*CW +: CW];
      if ($urandom_range(0, 3) == 0) x ^= CW'(1 << $urandom_range(0, CW - 1));
      load_key(key, x, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB + 1)) : NB,
               int'($urandom_range(0, 7)));
      if (m_armed)
        repeat (3) do_eval(NPI'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    start_load();
    cfg_beat(8'h12, 1'b0, ok);
    cfg_beat(8'h0F, 1'b0, ok);
    async_reset();

    load_key(32'hA5C30F12, 8'h7B, NB, -1);
    @(negedge clk); req_valid = 1'b1; req_data = 18'h15555;
    @(posedge clk); #1; req_valid = 1'b0;
    check("mid_eval_core_pi", core_pi, 18'h15555);
    async_reset();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) fail_now("scoreboard_drain: expected responses never seen");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
